// File: rtl/button_evt_pkg.sv
// button_evt_pkg: shared event-type and FSM-state encodings plus default sizing
// constants for the button event controller.
package button_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS     = 2'b00,
        EVT_SHORT_REL = 2'b01,
        EVT_LONG_HOLD = 2'b10,
        EVT_LONG_REL  = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_LONG    = 2'b10
    } btn_state_e;

    localparam int DEF_NUM_BTN    = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_LONG_TICKS = 1000;

endpackage

// File: rtl/btn_press_fsm.sv
// btn_press_fsm: per-button press classifier (IDLE/PRESSED/LONG), hold counter and
// one-deep pending event slot.
//   clk, n_reset : clock, synchronous active-low reset
//   tick         : timebase strobe that advances the hold counter
//   db_in        : debounced level of this button, 1 = pressed
//   slot_clr     : the arbiter takes the pending event this cycle
//   slot_valid   : an event is pending
//   slot_type    : type of the pending event
//   ovf_set      : pulse, a new event was dropped because the slot was full
module btn_press_fsm
    import button_evt_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LONG_TICKS = DEF_LONG_TICKS
) (
    input  logic      clk,
    input  logic      n_reset,
    input  logic      tick,
    input  logic      db_in,
    input  logic      slot_clr,
    output logic      slot_valid,
    output evt_type_e slot_type,
    output logic      ovf_set
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LONG_TICKS - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             slot_valid_q, slot_valid_d;
    evt_type_e        slot_type_q, slot_type_d;
    logic             rise, fall, post, slot_free;
    evt_type_e        post_type;

    assign rise = db_in & ~prev_q;
    assign fall = ~db_in & prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = db_in;
        post      = 1'b0;
        post_type = EVT_PRESS;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    post    = 1'b1;
                end
            end
            ST_PRESSED: begin
                // A release wins over a long-threshold tick in the same cycle.
                if (fall) begin
                    state_d   = ST_IDLE;
                    post      = 1'b1;
                    post_type = EVT_SHORT_REL;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d   = ST_LONG;
                        post      = 1'b1;
                        post_type = EVT_LONG_HOLD;
                    end
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    post      = 1'b1;
                    post_type = EVT_LONG_REL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A slot being taken by the arbiter this cycle counts as empty.
        slot_free    = ~slot_valid_q | slot_clr;
        slot_valid_d = (post & slot_free) | (slot_valid_q & ~slot_clr);
        slot_type_d  = (post & slot_free) ? post_type : slot_type_q;
        ovf_set      = post & ~slot_free;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_type_q  <= EVT_PRESS;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            slot_valid_q <= slot_valid_d;
            slot_type_q  <= slot_type_d;
        end
    end

    assign slot_valid = slot_valid_q;
    assign slot_type  = slot_type_q;

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into PRESS / SHORT_REL /
// LONG_HOLD / LONG_REL events, arbitrated round-robin onto a valid/ready stream.
//   clk, n_reset : clock, synchronous active-low reset
//   tick         : timebase strobe for hold counting
//   db_in        : debounced button levels, 1 = pressed
//   evt_valid, evt_ready, evt_id, evt_type : registered event stream
//   overflow     : sticky per-button dropped-event flags
//   clr_ovf      : pulse clearing all overflow flags (a same-cycle set wins)
module button_event_ctrl
    import button_evt_pkg::*;
#(
    parameter int NUM_BTN    = DEF_NUM_BTN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    localparam int ID_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] db_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [1:0]         evt_type,
    output logic [NUM_BTN-1:0] overflow,
    input  logic               clr_ovf
);

    logic [NUM_BTN-1:0] slot_valid, slot_clr, ovf_set;
    evt_type_e          slot_type [NUM_BTN];

    logic               evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]    evt_id_q, evt_id_d;
    evt_type_e          evt_type_q, evt_type_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [NUM_BTN-1:0] overflow_q, overflow_d;

    logic               gnt_found, load, take;
    logic [ID_W-1:0]    gnt_idx, cand;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_press_fsm #(
            .CNT_W      (CNT_W),
            .LONG_TICKS (LONG_TICKS)
        ) u_fsm (
            .clk        (clk),
            .n_reset    (n_reset),
            .tick       (tick),
            .db_in      (db_in[g]),
            .slot_clr   (slot_clr[g]),
            .slot_valid (slot_valid[g]),
            .slot_type  (slot_type[g]),
            .ovf_set    (ovf_set[g])
        );
        assign slot_clr[g] = take & (gnt_idx == ID_W'(g));
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Scan from the round-robin pointer upward, wrapping, first pending wins.
        for (int k = 0; k < NUM_BTN; k++) begin
            cand = ID_W'((int'(rr_q) + k) % NUM_BTN);
            if (!gnt_found && slot_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        load        = ~evt_valid_q | evt_ready;
        take        = load & gnt_found;
        evt_valid_d = load ? gnt_found : evt_valid_q;
        evt_id_d    = take ? gnt_idx : evt_id_q;
        evt_type_d  = take ? slot_type[gnt_idx] : evt_type_q;
        rr_d        = take ? ((gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + 1'b1) : rr_q;
        overflow_d  = ovf_set | (overflow_q & ~{NUM_BTN{clr_ovf}});
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_PRESS;
            rr_q        <= '0;
            overflow_q  <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_type_q  <= evt_type_d;
            rr_q        <= rr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_type  = evt_type_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed self-checking bench for button_event_ctrl
// (NUM_BTN=4, LONG_TICKS=8); accepted events are logged for ordering checks.
module tb_button_event_ctrl;
    import button_evt_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset, tick, evt_ready, clr_ovf;
    logic [3:0] db_in;
    logic       evt_valid;
    logic [1:0] evt_id, evt_type;
    logic [3:0] overflow;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] lg_id   [64];
    logic [1:0] lg_type [64];
    int         lg_n = 0;
    int         b;

    button_event_ctrl #(
        .NUM_BTN    (4),
        .CNT_W      (16),
        .LONG_TICKS (8)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .tick      (tick),
        .db_in     (db_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_reset && evt_valid && evt_ready && lg_n < 64) begin
            lg_id[lg_n]   <= evt_id;
            lg_type[lg_n] <= evt_type;
            lg_n          <= lg_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [1:0] ty);
        chk(tag, {29'd0, evt_valid, evt_id, evt_type}, {29'd0, v, id, ty});
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [1:0] id, input logic [1:0] ty);
        chk(tag, {28'd0, lg_id[idx], lg_type[idx]}, {28'd0, id, ty});
    endtask

    task automatic tick_cycle();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    initial begin
        n_reset = 1'b0; tick = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0; db_in = 4'h0;
        step(); step();
        chk("reset valid", {31'd0, evt_valid}, 32'd0);
        chk("reset ovf", {28'd0, overflow}, 32'd0);
        chk_out("reset out", 1'b0, 2'd0, EVT_PRESS);
        n_reset = 1'b1;
        step();

        // four buttons rise together -> PRESS 0,1,2,3 back to back
        evt_ready = 1'b1;
        db_in = 4'hF;
        step();
        chk_out("all latency", 1'b0, 2'd0, EVT_PRESS);
        step(); chk_out("all id0", 1'b1, 2'd0, EVT_PRESS);
        step(); chk_out("all id1", 1'b1, 2'd1, EVT_PRESS);
        step(); chk_out("all id2", 1'b1, 2'd2, EVT_PRESS);
        step(); chk_out("all id3", 1'b1, 2'd3, EVT_PRESS);
        step(); chk("all drained", {31'd0, evt_valid}, 32'd0);
        db_in = 4'h0;
        step(); step();
        chk_out("all rel0", 1'b1, 2'd0, EVT_SHORT_REL);
        repeat (5) step();
        chk("all count", lg_n, 8);

        // short press on btn0
        b = lg_n;
        db_in = 4'b0001;
        step(); chk("short latency", {31'd0, evt_valid}, 32'd0);
        step(); chk_out("short press", 1'b1, 2'd0, EVT_PRESS);
        step(); chk("short idle", {31'd0, evt_valid}, 32'd0);
        repeat (5) tick_cycle();
        chk("short no hold", lg_n - b, 1);
        db_in = 4'b0000;
        repeat (4) step();
        chk("short count", lg_n - b, 2);
        chk_log("short e0", b, 2'd0, EVT_PRESS);
        chk_log("short e1", b + 1, 2'd0, EVT_SHORT_REL);

        // long press on btn2, 20 ticks
        b = lg_n;
        db_in = 4'b0100;
        repeat (3) step();
        for (int i = 1; i <= 20; i++) begin
            tick_cycle();
            if (i == 7) chk("long before 8", lg_n - b, 1);
            if (i == 8) chk_out("long hold", 1'b1, 2'd2, EVT_LONG_HOLD);
        end
        db_in = 4'b0000;
        repeat (4) step();
        chk("long count", lg_n - b, 3);
        chk_log("long e0", b, 2'd2, EVT_PRESS);
        chk_log("long e1", b + 1, 2'd2, EVT_LONG_HOLD);
        chk_log("long e2", b + 2, 2'd2, EVT_LONG_REL);

        // back-pressure on btn1: stable output, drops, clr_ovf beaten by a same-cycle set
        b = lg_n;
        evt_ready = 1'b0;
        db_in = 4'b0010;
        step(); step();
        chk_out("bp press", 1'b1, 2'd1, EVT_PRESS);
        db_in = 4'b0000;
        step();
        chk_out("bp stable1", 1'b1, 2'd1, EVT_PRESS);
        chk("bp ovf none", {28'd0, overflow}, 32'd0);
        db_in = 4'b0010; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("bp ovf set wins", {28'd0, overflow}, 32'h2);
        db_in = 4'b0000;
        step();
        chk("bp ovf sticky", {28'd0, overflow}, 32'h2);
        chk_out("bp stable2", 1'b1, 2'd1, EVT_PRESS);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("bp ovf clr", {28'd0, overflow}, 32'd0);
        evt_ready = 1'b1;
        step(); chk_out("bp kept rel", 1'b1, 2'd1, EVT_SHORT_REL);
        step(); chk("bp drained", {31'd0, evt_valid}, 32'd0);
        chk("bp count", lg_n - b, 2);

        // btn3: handshake frees the slot in the same cycle as a new post
        evt_ready = 1'b0;
        db_in = 4'b1000;
        step(); step();
        chk_out("same press", 1'b1, 2'd3, EVT_PRESS);
        db_in = 4'b0000;
        step();
        db_in = 4'b1000; evt_ready = 1'b1;
        step();
        chk_out("same rel", 1'b1, 2'd3, EVT_SHORT_REL);
        chk("same ovf", {28'd0, overflow}, 32'd0);
        step(); chk_out("same repress", 1'b1, 2'd3, EVT_PRESS);
        step(); chk("same drained", {31'd0, evt_valid}, 32'd0);
        db_in = 4'b0000;
        repeat (4) step();
        chk("same ovf end", {28'd0, overflow}, 32'd0);

        // reset while btn1 is in LONG with LONG_HOLD in flight
        b = lg_n;
        db_in = 4'b0010;
        repeat (3) step();
        repeat (7) tick_cycle();
        tick = 1'b1;
        step();
        tick = 1'b0; n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        chk_out("rst out", 1'b0, 2'd0, EVT_PRESS);
        chk("rst ovf", {28'd0, overflow}, 32'd0);
        chk("rst no hold", lg_n - b, 1);
        step(); chk("rst latency", {31'd0, evt_valid}, 32'd0);
        step(); chk_out("rst repress", 1'b1, 2'd1, EVT_PRESS);
        step();
        chk("rst count", lg_n - b, 2);
        chk_log("rst e1", b + 1, 2'd1, EVT_PRESS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
